// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode field values and the fetch-unit state encoding.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_I,
        LOAD_I,
        LOAD_M,
        ISSUE,
        IMM,
        WAIT,
        HALTED
    } fetch_state_e;

    function automatic logic is_mvi(input logic [8:0] word);
        return word[8:6] == OP_MVI;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter for the fetch unit: clear to zero, increment, natural wrap at 2**ADDR_W.
module pc_counter #(
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              load_zero,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_zero) begin
            pc_d = '0;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue sequencer feeding a multi-cycle processor from a synchronous program memory.
// Define FETCH_HALT_EN to make opcode 3'b111 stop fetching (state HALTED) instead of issuing it.
module instr_fetch
    import proc_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [8:0]        MemData,
    output logic [8:0]        DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted
);

    fetch_state_e      state_d, state_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [8:0]        din_d, din_q;
    logic [8:0]        ir_d, ir_q;
    logic [8:0]        imm_d, imm_q;
    logic              run_d, run_q;
    logic              busy_d, busy_q;
    logic              pc_load_zero;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;
    logic              halt_op;

`ifdef FETCH_HALT_EN
    assign halt_op = (MemData[8:6] == OP_HALT);
`else
    assign halt_op = 1'b0;
`endif

    pc_counter #(
        .ADDR_W(ADDR_W)
    ) u_pc (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .load_zero(pc_load_zero),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // The address register is one step ahead of the state: leaving FETCH_I it already
    // points at PC+1 so the immediate word of an mvi arrives during LOAD_M.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        din_d        = din_q;
        ir_d         = ir_q;
        imm_d        = imm_q;
        run_d        = 1'b0;
        pc_load_zero = 1'b0;
        pc_inc       = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    pc_load_zero = 1'b1;
                    mem_addr_d   = '0;
                    state_d      = FETCH_I;
                end
            end
            FETCH_I: begin
                mem_addr_d = pc + ADDR_W'(1);
                state_d    = LOAD_I;
            end
            LOAD_I: begin
                ir_d = MemData;
                if (halt_op) begin
                    mem_addr_d = pc;
                    state_d    = HALTED;
                end else begin
                    pc_inc = 1'b1;
                    if (is_mvi(MemData)) begin
                        state_d = LOAD_M;
                    end else begin
                        din_d   = MemData;
                        run_d   = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            LOAD_M: begin
                imm_d   = MemData;
                pc_inc  = 1'b1;
                din_d   = ir_q;
                run_d   = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (is_mvi(ir_q)) begin
                    din_d   = imm_q;
                    state_d = IMM;
                end else begin
                    state_d = WAIT;
                end
            end
            IMM: begin
                if (Done) begin
                    mem_addr_d = pc;
                    state_d    = FETCH_I;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (Done) begin
                    mem_addr_d = pc;
                    state_d    = FETCH_I;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) && (state_d != HALTED);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            din_q      <= '0;
            ir_q       <= '0;
            imm_q      <= '0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            din_q      <= din_d;
            ir_q       <= ir_d;
            imm_q      <= imm_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_d, halted_q;

    assign halted_d = (state_d == HALTED);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign Halted = halted_q;
`else
    assign Halted = 1'b0;
`endif

    assign MemAddr = mem_addr_q;
    assign DIN     = din_q;
    assign Run     = run_q;
    assign Busy    = busy_q;

endmodule
